// File: rtl/mux_tree_nx1_pipe.sv
// Pipelined N:1 word multiplexer (4:1 groups, then G:1) with valid/ready handshake and auto-scan.
// Optional even-parity output `out_par` when MUX_OUT_PARITY_EN is defined.
module mux_tree_nx1_pipe #(
  parameter  int N  = 8,
  parameter  int W  = 8,
  localparam int SW = $clog2(N),
  localparam int G  = ((N / 4) > 1) ? (N / 4) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  a,
  input  logic [SW-1:0]   s,
  input  logic            mode,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [W-1:0]    out,
  output logic [SW-1:0]   out_ch,
  output logic            out_valid,
  input  logic            out_ready
`ifdef MUX_OUT_PARITY_EN
  ,
  output logic            out_par
`endif
);

  localparam int LW = (SW >= 2) ? 2 : 1;
  localparam int HW = (SW > 2) ? (SW - 2) : 1;

  logic [SW-1:0] r_scan;
  logic [W-1:0]  r_grp_p1 [G];
  logic [SW-1:0] r_sel_p1;
  logic          r_vld_p1;
  logic [W-1:0]  r_out_p2;
  logic [SW-1:0] r_ch_p2;
  logic          r_vld_p2;

  logic [SW-1:0] w_sel;
  logic [LW-1:0] w_lo;
  logic [HW-1:0] w_hi;
  logic [W-1:0]  w_grp [G];
  logic          w_load_p2;
  logic          w_acc;

  assign w_load_p2 = !r_vld_p2 || out_ready;
  assign in_ready  = !r_vld_p1 || w_load_p2;
  assign w_acc     = in_valid && in_ready;

  assign w_sel = mode ? r_scan : s;
  assign w_lo  = w_sel[LW-1:0];

  always_comb begin
    for (int g = 0; g < G; g++) begin
      w_grp[g] = a[(4 * g + int'(w_lo)) * W +: W];
    end
  end

  // Group index for the final stage; small trees have only group 0.
  generate
    if (SW > 2) begin : g_hi
      assign w_hi = r_sel_p1[SW-1:2];
    end else begin : g_hi0
      assign w_hi = '0;
    end
  endgenerate

  // Scan counter: cleared in manual mode so auto-scan always starts at channel 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan <= '0;
    end else if (!mode) begin
      r_scan <= '0;
    end else if (w_acc) begin
      r_scan <= r_scan + SW'(1);
    end
  end

  // Stage 1: per-group 4:1 selection on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_sel_p1 <= '0;
      for (int g = 0; g < G; g++) r_grp_p1[g] <= '0;
    end else if (w_acc) begin
      r_vld_p1 <= 1'b1;
      r_sel_p1 <= w_sel;
      for (int g = 0; g < G; g++) r_grp_p1[g] <= w_grp[g];
    end else if (w_load_p2) begin
      r_vld_p1 <= 1'b0;
    end
  end

  // Stage 2: group select, output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2 <= 1'b0;
      r_out_p2 <= '0;
      r_ch_p2  <= '0;
    end else if (w_load_p2) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_out_p2 <= r_grp_p1[w_hi];
        r_ch_p2  <= r_sel_p1;
      end
    end
  end

  assign out       = r_out_p2;
  assign out_ch    = r_ch_p2;
  assign out_valid = r_vld_p2;

`ifdef MUX_OUT_PARITY_EN
  logic r_par_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par_p2 <= 1'b0;
    end else if (w_load_p2 && r_vld_p1) begin
      r_par_p2 <= ^r_grp_p1[w_hi];
    end
  end

  assign out_par = r_par_p2;
`endif

endmodule

// File: doc/mux_tree_nx1_pipe.md
# mux_tree_nx1_pipe

Parametrised, pipelined N:1 multiplexer for W-bit words, built as a two-level tree: 4:1 groups, then a final G:1 stage. Adds a valid/ready handshake, fixed 2-cycle latency and an auto-scan mode in which an internal channel counter steps through all inputs. Serves as the general channel-select / sample-serialiser block wherever the design needs more than 8 inputs, wide data or back-pressure.

## Interface

Parameters:
- N, default 8: channel count; power of 2, 2..64.
- W, default 8: data width per channel, ≥1.
- SW, derived $clog2(N): select width. G, derived max(1, N/4): group count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- a  input  N*W  channel data; channel k = a[k*W +: W].
- s  input  SW  manual select; used when mode=0.
- mode  input  1  0 = manual select, 1 = auto-scan.
- in_valid  input  1  request to sample a.
- in_ready  output  1  block can accept this cycle.
- out  output  W  selected word.
- out_ch  output  SW  channel index that produced out.
- out_valid  output  1  out/out_ch valid.
- out_ready  input  1  consumer takes out this cycle.
- out_par  output  1  present only with MUX_OUT_PARITY_EN.

## Operation

- Accept = in_valid && in_ready. Effective select sel = mode ? scan_ch : s, evaluated in the accept cycle.
- Stage 1 (on accept): for each group g, register a[(4g+sel[1:0])*W +: W]; for N=2 the single group uses sel[0] only. Also register sel; set v1.
- Stage 2: picks group sel[SW-1:2] (group 0 when N≤4) from stage-1 words; registers out and out_ch = stage-1 sel; sets out_valid.
- Inputs a and s are don't-care outside the accept cycle; captured data does not change after a later change of a.
- Pipeline advance: stage 2 loads when !out_valid || out_ready. Stage 1 moves to stage 2 on that condition; in_ready = !v1 || (stage 2 loading). Capacity 2 beats.
- out_valid drops after a transfer (out_valid && out_ready) if stage 1 is empty.
- Scan counter scan_ch (SW bits): in mode=1 increments on every accept, wraps N-1 → 0. In mode=0 held at 0, so entering mode=1 always starts at channel 0. Never increments on a non-accept cycle.
- Mode change with beats in flight: in-flight beats complete unchanged; the new mode applies from the next accept.

## Timing

- Reset (rst=1 at edge): v1=0, out_valid=0, out=0, out_ch=0, scan_ch=0, stage-1 registers=0; in_ready=1 in the cycle after reset. Reset mid-operation discards both stages with no partial output.
- Latency: accept in cycle t → out_valid=1 with the data in cycle t+2 when out_ready stayed high.
- Throughput: 1 beat/cycle with out_ready=1.
- Stall: while out_valid && !out_ready, out and out_ch are held stable; a second beat may be accepted into stage 1, then in_ready=0.
- Simultaneous transfer and accept with both stages full: stage 1 → stage 2, new beat → stage 1, no bubble, no loss.
- in_ready is combinational from out_valid, out_ready and v1 only (no path from in_valid).

## Configuration

- MUX_OUT_PARITY_EN defined: out_par port exists, registered with stage 2, out_par = ^out (even parity, odd-count of ones → 1); reset 0; held with out during stall.
- Not defined: port and logic absent; all other behaviour identical.

## Test plan

N=8, W=8, a channel k = 8'h11*k (a = 64'h7766554433221100) unless stated.
- Manual: mode=0, s=5, one-cycle in_valid, out_ready=1 → out=8'h55, out_ch=5, out_valid high exactly 2 cycles after accept, for one cycle.
- Back-pressure: out_ready=0, in_valid held, s=3 then s=6 → two accepts, then in_ready=0; out=8'h33 held stable; release out_ready → 8'h33 then 8'h66 in order, no loss or duplicate.
- Scan: mode=1, in_valid=1, out_ready=1 for 10 cycles → out_ch sequence 0..7,0,1; out 8'h00..8'h77,8'h00,8'h11.
- Scan under random out_ready/in_valid → each channel appears once per 8 outputs in order; scan_ch unchanged on non-accept cycles.
- Reset mid-operation: both stages full, rst=1 one cycle → next cycle out_valid=0, out=0, in_ready=1; next scan starts at out_ch=0.
- Parity (macro on): s=7 (8'h77) → out_par=0; a channel 1 = 8'h01, s=1 → out_par=1; N=64, W=16 sweep of all s → out matches a[s*16 +: 16].
